brq_mem_arbiter: RTL and testbench

//  Shares one downstream req/gnt/rvalid memory port between the core's instruction and data

---
 rtl/brq_pkg.sv | 10 +
 rtl/brq_arb_fifo.sv | 53 +++++
 rtl/brq_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_brq_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types for the brq memory arbiter: requester id and arbiter FSM states.
package brq_pkg;

    typedef enum logic {ARB_INSTR = 1'b0, ARB_DATA = 1'b1} arb_src_e;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_e;

    // Instruction fetches are always full-word reads.
    localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/brq_arb_fifo.sv
// Order FIFO of requester ids: one entry per granted downstream request,
// popped by each downstream response so responses route in issue order.
module brq_arb_fifo
    import brq_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push,
    input  arb_src_e                     push_src,
    input  logic                         pop,
    output arb_src_e                     head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    arb_src_e        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic            push_ok, pop_ok;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr];

    // Storage, pointers and occupancy; reset flushes everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= ARB_INSTR;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr] <= push_src;
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/brq_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction and data sides.
// Data wins by default; a starving instruction request wins once it has lost
// StarveLimit cycles. Optional stall counters under BRQ_MEM_ARB_PERF_EN.
module brq_mem_arbiter
    import brq_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o,
    output logic        unexpected_rsp_o
`ifdef BRQ_MEM_ARB_PERF_EN
    ,
    output logic [31:0] instr_stall_cnt_o,
    output logic [31:0] data_stall_cnt_o
`endif
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned StW  = $clog2(StarveLimit + 1);

    arb_state_e      state_q, state_d;
    arb_src_e        hold_owner_q, owner, head;
    logic [StW-1:0]  starve_q;
    logic [CntW-1:0] fifo_count;
    logic            starved, sel_instr, win_req;
    logic            fifo_full, fifo_empty, push, pop;

    assign starved = (starve_q == StW'(StarveLimit));
    assign push    = mem_req_o && mem_gnt_i;
    assign pop     = mem_rvalid_i && !fifo_empty;

    brq_arb_fifo #(.Depth(MaxOutstanding)) u_order_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_src (owner),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: park in HOLD while a presented request is not accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_req_o && !mem_gnt_i) state_d = HOLD;
            HOLD:    if (mem_gnt_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pick the owner, drive downstream fields, 0-latency grant.
    always_comb begin
        sel_instr = instr_req_i && (!data_req_i || starved);
        if (state_q == HOLD) begin
            owner   = hold_owner_q;
            win_req = 1'b1;
        end else begin
            owner   = sel_instr ? ARB_INSTR : ARB_DATA;
            win_req = sel_instr || data_req_i;
        end
        // A pop in this cycle does not free a slot: gate on registered full.
        mem_req_o = win_req && !fifo_full;
        if (owner == ARB_INSTR) begin
            mem_we_o    = 1'b0;
            mem_be_o    = INSTR_BE;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = '0;
        end else begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
        instr_gnt_o = push && (owner == ARB_INSTR);
        data_gnt_o  = push && (owner == ARB_DATA);
    end

    // Latch the owner on entry to HOLD so it cannot change until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                             hold_owner_q <= ARB_INSTR;
        else if (state_q == IDLE && mem_req_o && !mem_gnt_i)   hold_owner_q <= owner;
    end

    // Starvation counter: cycles instr waited without grant, saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                        starve_q <= '0;
        else if (instr_gnt_o)             starve_q <= '0;
        else if (instr_req_i && !starved) starve_q <= starve_q + 1'b1;
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                           unexpected_rsp_o <= 1'b0;
        else if (mem_rvalid_i && fifo_empty) unexpected_rsp_o <= 1'b1;
    end

    assign instr_rvalid_o = pop && (head == ARB_INSTR);
    assign data_rvalid_o  = pop && (head == ARB_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;
    assign busy_o         = (fifo_count != '0);

`ifdef BRQ_MEM_ARB_PERF_EN
    // Stall counters: cycles each requester is held off; wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_stall_cnt_o <= '0;
            data_stall_cnt_o  <= '0;
        end else begin
            if (instr_req_i && !instr_gnt_o) instr_stall_cnt_o <= instr_stall_cnt_o + 32'd1;
            if (data_req_i && !data_gnt_o)   data_stall_cnt_o  <= data_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Bench for brq_mem_arbiter: directed vectors with literal checks plus a
// queue-based model compared against the DUT on every cycle.
module tb_brq_mem_arbiter;

    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 0, data_req = 0, data_we = 0, mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
    logic [31:0] instr_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
    logic [3:0]  data_be = 0;
    logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
    logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, busy, unexpected;
    logic [3:0]  mem_be;
`ifdef BRQ_MEM_ARB_PERF_EN
    logic [31:0] instr_stall_cnt, data_stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    brq_mem_arbiter #(.MaxOutstanding(MAXO), .StarveLimit(SL)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata), .data_err_o(data_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .busy_o(busy), .unexpected_rsp_o(unexpected)
`ifdef BRQ_MEM_ARB_PERF_EN
        , .instr_stall_cnt_o(instr_stall_cnt), .data_stall_cnt_o(data_stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: issue-order queue of owners (0=instr, 1=data), pending hold, wait count.
    int md_q[$];
    bit md_hold;
    int md_hold_own;
    int md_starve;
    bit md_unexp;

    always @(negedge clk) begin : model
        int own;
        bit req, igr, dgr, irv, drv;
        if (rst) begin
            md_q.delete();
            md_hold   = 0;
            md_starve = 0;
            md_unexp  = 0;
            chk("m_rst_busy", busy, 0);
            chk("m_rst_unexp", unexpected, 0);
        end else begin
            if (md_hold) begin
                own = md_hold_own; req = 1;
            end else if (instr_req && (!data_req || md_starve == SL)) begin
                own = 0; req = 1;
            end else begin
                own = 1; req = data_req;
            end
            if (md_q.size() >= MAXO) req = 0;
            igr = req && mem_gnt && own == 0;
            dgr = req && mem_gnt && own == 1;
            irv = mem_rvalid && md_q.size() > 0 && md_q[0] == 0;
            drv = mem_rvalid && md_q.size() > 0 && md_q[0] == 1;
            chk("m_mem_req", mem_req, req);
            chk("m_instr_gnt", instr_gnt, igr);
            chk("m_data_gnt", data_gnt, dgr);
            chk("m_instr_rvalid", instr_rvalid, irv);
            chk("m_data_rvalid", data_rvalid, drv);
            chk("m_busy", busy, md_q.size() != 0);
            chk("m_unexp", unexpected, md_unexp);
            if (req) begin
                chk("m_addr", mem_addr, own == 0 ? instr_addr : data_addr);
                chk("m_we", mem_we, own == 0 ? 1'b0 : data_we);
                chk("m_be", mem_be, own == 0 ? 4'hF : data_be);
                chk("m_wdata", mem_wdata, own == 0 ? 32'h0 : data_wdata);
            end
            if (irv) begin
                chk("m_irdata", instr_rdata, mem_rdata);
                chk("m_ierr", instr_err, mem_err);
            end
            if (drv) begin
                chk("m_drdata", data_rdata, mem_rdata);
                chk("m_derr", data_err, mem_err);
            end
            if (mem_rvalid) begin
                if (md_q.size() > 0) void'(md_q.pop_front());
                else md_unexp = 1;
            end
            if (igr || dgr) md_q.push_back(own);
            md_hold     = req && !mem_gnt;
            md_hold_own = own;
            if (igr) md_starve = 0;
            else if (instr_req && md_starve < SL) md_starve++;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_gnts", {instr_gnt, data_gnt}, 0);
        tick();
        rst = 0;

        // Both request together: data first, then instr.
        instr_req = 1; instr_addr = 32'h200;
        data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h100; data_wdata = 32'hDEAD;
        mem_gnt = 1;
        @(negedge clk);
        chk("t1_dgnt_c0", data_gnt, 1);
        chk("t1_ignt_c0", instr_gnt, 0);
        chk("t1_addr_c0", mem_addr, 32'h100);
        tick(); data_req = 0; mem_rvalid = 1; mem_rdata = 32'h11;
        @(negedge clk);
        chk("t1_ignt_c1", instr_gnt, 1);
        chk("t1_be_c1", mem_be, 4'hF);
        chk("t1_drv", data_rvalid, 1);
        chk("t1_drdata", data_rdata, 32'h11);
        tick(); instr_req = 0; mem_rdata = 32'h22;
        @(negedge clk);
        chk("t1_irv", instr_rvalid, 1);
        tick(); mem_rvalid = 0;
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);

        // Instr then data issued; responses A, B route in issue order.
        tick(); instr_req = 1; instr_addr = 32'h300;
        tick(); instr_req = 0; data_req = 1; data_we = 0; data_addr = 32'h304;
        tick(); data_req = 0; mem_rvalid = 1; mem_rdata = 32'hA;
        @(negedge clk);
        chk("t3_irv", instr_rvalid, 1);
        chk("t3_irdata", instr_rdata, 32'hA);
        chk("t3_drv_low", data_rvalid, 0);
        tick(); mem_rdata = 32'hB; mem_err = 1;
        @(negedge clk);
        chk("t3_drv", data_rvalid, 1);
        chk("t3_drdata", data_rdata, 32'hB);
        chk("t3_derr", data_err, 1);
        tick(); mem_rvalid = 0; mem_err = 0;

        // Two grants fill the FIFO; a pop in the full cycle does not free a slot.
        tick(); data_req = 1; data_addr = 32'h400;
        tick(); data_addr = 32'h404;
        tick(); data_addr = 32'h408;
        @(negedge clk);
        chk("t4_full_req", mem_req, 0);
        chk("t4_full_gnt", data_gnt, 0);
        tick(); mem_rvalid = 1;
        @(negedge clk);
        chk("t4_full_pop_req", mem_req, 0);
        tick(); mem_rvalid = 0;
        @(negedge clk);
        chk("t4_reissue_req", mem_req, 1);
        chk("t4_reissue_gnt", data_gnt, 1);
        tick(); data_req = 0; mem_rvalid = 1;
        tick();
        tick(); mem_rvalid = 0;

        // HOLD: downstream stalls 5 cycles; owner stays data while instr waits.
        tick(); mem_gnt = 0; data_req = 1; data_we = 1; data_addr = 32'h500;
        instr_req = 1; instr_addr = 32'h600;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_req", mem_req, 1);
            chk("t5_hold_addr", mem_addr, 32'h500);
            chk("t5_hold_we", mem_we, 1);
            chk("t5_hold_ignt", instr_gnt, 0);
            tick();
        end
        mem_gnt = 1;
        @(negedge clk);
        chk("t5_dgnt", data_gnt, 1);
        tick(); data_req = 0;
        @(negedge clk);
        chk("t5_ignt", instr_gnt, 1);
        tick(); instr_req = 0; mem_rvalid = 1;
        @(negedge clk);
        chk("t5_drv", data_rvalid, 1);
        tick();
        @(negedge clk);
        chk("t5_irv", instr_rvalid, 1);
        tick(); mem_rvalid = 0;

        // Starvation: data always requesting, instr wins on its 5th waiting cycle.
        tick(); data_req = 1; data_we = 0; data_addr = 32'h800; instr_req = 1; instr_addr = 32'h700;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) mem_rvalid = 1;
            @(negedge clk);
            if (k < SL) begin
                chk("t2_dgnt", data_gnt, 1);
                chk("t2_ignt_low", instr_gnt, 0);
            end else begin
                chk("t2_ignt_starved", instr_gnt, 1);
                chk("t2_dgnt_low", data_gnt, 0);
            end
            tick(); data_addr = data_addr + 32'd4;
        end
        instr_req = 0;
        @(negedge clk);
        chk("t2_dgnt_after", data_gnt, 1);
        tick(); data_req = 0;
        tick(); mem_rvalid = 0;
        @(negedge clk);
        chk("t2_drained", busy, 0);

        // Unexpected response is sticky until reset.
        tick(); mem_rvalid = 1;
        @(negedge clk);
        chk("t6_no_irv", instr_rvalid, 0);
        chk("t6_no_drv", data_rvalid, 0);
        tick(); mem_rvalid = 0;
        @(negedge clk);
        chk("t6_unexp_set", unexpected, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_unexp_sticky", unexpected, 1);
        tick(); rst = 1;
        @(negedge clk);
        chk("t6_unexp_rst", unexpected, 0);
        tick(); rst = 0;

        // Reset mid-transaction flushes the FIFO; the late response is unexpected.
        tick(); data_req = 1; data_addr = 32'h900;
        @(negedge clk);
        chk("t7_dgnt", data_gnt, 1);
        tick(); data_req = 0;
        @(negedge clk);
        chk("t7_busy", busy, 1);
        tick(); rst = 1;
        tick(); rst = 0; mem_rvalid = 1;
        @(negedge clk);
        chk("t7_late_no_drv", data_rvalid, 0);
        tick(); mem_rvalid = 0;
        @(negedge clk);
        chk("t7_late_unexp", unexpected, 1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
